// File: rtl/cga_attrib_pipe.sv
// CGA attribute/colour pipeline: picks a 4-bit colour index from text, graphics or
// overscan sources, then maps it through a writable palette into a registered pixel.
module cga_attrib_pipe #(
  parameter int unsigned PIX_W     = 4,
  parameter int unsigned BLINK_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_ce,
  input  logic [7:0]       att_byte,
  input  logic [7:0]       cga_color_reg,
  input  logic             grph_mode,
  input  logic             bw_mode,
  input  logic             mode_640,
  input  logic             tandy_16_mode,
  input  logic             blink_enabled,
  input  logic             display_enable,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             cursor,
  input  logic             blink,
  input  logic             pix_in,
  input  logic             c0,
  input  logic             c1,
  input  logic             pix_640,
  input  logic [3:0]       pix_tandy,
  input  logic             pal_we,
  input  logic [3:0]       pal_addr,
  input  logic [PIX_W-1:0] pal_data,
  output logic [PIX_W-1:0] pix_out,
  output logic             pix_valid
);

  logic [1:0]       r_blink_sr;
  logic [3:0]       r_blink_cnt;
  logic             r_blinkdiv;
  logic [3:0]       r_idx;
  logic             r_blank;
  logic             r_s1_valid;
  logic [PIX_W-1:0] r_pal [16];

  logic       w_blink_rise;
  logic       w_alpha_dots;
  logic       w_mux_a;
  logic       w_mux_b;
  logic [3:0] w_bg;
  logic [3:0] w_grph_idx;
  logic [3:0] w_idx;
  logic       w_blank;
  logic       w_unused;

  assign w_unused = ^cga_color_reg[7:6];

  assign w_blink_rise = (r_blink_sr == 2'b01);

  // Blinking attribute hides the foreground during the off phase unless the cursor covers it.
  assign w_alpha_dots = (pix_in & (~(blink_enabled & att_byte[7] & ~cursor) | ~r_blinkdiv))
                      | (cursor & blink);

  assign w_mux_b = grph_mode | ~display_enable;
  assign w_mux_a = ~display_enable
                 | (grph_mode ? (tandy_16_mode ? 1'b0 : ~(~mode_640 & (c0 | c1)))
                              : ~w_alpha_dots);

  assign w_bg       = blink_enabled ? {1'b0, att_byte[6:4]} : att_byte[7:4];
  assign w_grph_idx = tandy_16_mode ? pix_tandy
                    : {cga_color_reg[4], c1, c0, bw_mode ? c0 : cga_color_reg[5]};
  assign w_blank    = hsync | vsync | (mode_640 & ~(display_enable & pix_640));

  always_comb begin
    w_idx = att_byte[3:0];
    case ({w_mux_b, w_mux_a})
      2'b00:   w_idx = att_byte[3:0];
      2'b01:   w_idx = w_bg;
      2'b10:   w_idx = w_grph_idx;
      default: w_idx = cga_color_reg[3:0];
    endcase
  end

  // Blink edge detect and divider run on every clk, independent of the pixel enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_sr  <= 2'b00;
      r_blink_cnt <= 4'd0;
      r_blinkdiv  <= 1'b0;
    end else begin
      r_blink_sr <= {r_blink_sr[0], blink};
      if (w_blink_rise) begin
        if (r_blink_cnt == 4'(BLINK_DIV - 1)) begin
          r_blink_cnt <= 4'd0;
          r_blinkdiv  <= ~r_blinkdiv;
        end else begin
          r_blink_cnt <= r_blink_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r_pal[i] <= PIX_W'(i);
    end else if (pal_we) begin
      r_pal[pal_addr] <= pal_data;
    end
  end

  // Stage 2 reads r_pal before this edge's write lands, so a same-cycle write shows next time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx      <= 4'd0;
      r_blank    <= 1'b1;
      r_s1_valid <= 1'b0;
      pix_out    <= '0;
      pix_valid  <= 1'b0;
    end else if (pix_ce) begin
      r_idx      <= w_idx;
      r_blank    <= w_blank;
      r_s1_valid <= 1'b1;
      pix_out    <= r_blank ? '0 : r_pal[r_idx];
      pix_valid  <= pix_valid | r_s1_valid;
    end
  end

endmodule

// File: tb/tb_cga_attrib_pipe.sv
// Directed bench for cga_attrib_pipe: expected pixels are queued at issue time and
// popped by per-instance monitors; a BLINK_DIV=1 copy shares all inputs.
module tb_cga_attrib_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_ce;
  logic [7:0] att_byte, cga_color_reg;
  logic       grph_mode, bw_mode, mode_640, tandy_16_mode, blink_enabled;
  logic       display_enable, hsync, vsync, cursor, blink;
  logic       pix_in, c0, c1, pix_640;
  logic [3:0] pix_tandy;
  logic       pal_we;
  logic [3:0] pal_addr;
  logic [3:0] pal_data;
  logic [3:0] pix_out2, pix_out1;
  logic       pix_valid2, pix_valid1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] q2[$];
  logic [3:0] q1[$];
  logic       r_ce_seen = 1'b0;

  always #5 clk = ~clk;

  cga_attrib_pipe #(.PIX_W(4), .BLINK_DIV(2)) dut2 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .att_byte(att_byte),
    .cga_color_reg(cga_color_reg), .grph_mode(grph_mode), .bw_mode(bw_mode),
    .mode_640(mode_640), .tandy_16_mode(tandy_16_mode), .blink_enabled(blink_enabled),
    .display_enable(display_enable), .hsync(hsync), .vsync(vsync), .cursor(cursor),
    .blink(blink), .pix_in(pix_in), .c0(c0), .c1(c1), .pix_640(pix_640),
    .pix_tandy(pix_tandy), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .pix_out(pix_out2), .pix_valid(pix_valid2)
  );

  cga_attrib_pipe #(.PIX_W(4), .BLINK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .att_byte(att_byte),
    .cga_color_reg(cga_color_reg), .grph_mode(grph_mode), .bw_mode(bw_mode),
    .mode_640(mode_640), .tandy_16_mode(tandy_16_mode), .blink_enabled(blink_enabled),
    .display_enable(display_enable), .hsync(hsync), .vsync(vsync), .cursor(cursor),
    .blink(blink), .pix_in(pix_in), .c0(c0), .c1(c1), .pix_640(pix_640),
    .pix_tandy(pix_tandy), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .pix_out(pix_out1), .pix_valid(pix_valid1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) r_ce_seen <= pix_ce;

  always @(negedge clk) begin
    if (r_ce_seen && pix_valid2) begin
      if (q2.size() == 0) chk("sb2_empty", 1, 0);
      else chk("sb2_pix", int'(pix_out2), int'(q2.pop_front()));
    end
    if (r_ce_seen && pix_valid1) begin
      if (q1.size() == 0) chk("sb1_empty", 1, 0);
      else chk("sb1_pix", int'(pix_out1), int'(q1.pop_front()));
    end
  end

  task automatic issue(input logic [3:0] e2, input logic [3:0] e1);
    pix_ce = 1'b1;
    q2.push_back(e2);
    q1.push_back(e1);
    @(negedge clk);
  endtask

  task automatic blink_pulse();
    pix_ce = 1'b0;
    blink  = 1'b1;
    repeat (2) @(negedge clk);
    blink  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; pix_ce = 1'b0;
    att_byte = 8'h1E; cga_color_reg = 8'h00;
    grph_mode = 0; bw_mode = 0; mode_640 = 0; tandy_16_mode = 0; blink_enabled = 0;
    display_enable = 1; hsync = 0; vsync = 0; cursor = 0; blink = 0;
    pix_in = 1; c0 = 0; c1 = 0; pix_640 = 0; pix_tandy = 4'h0;
    pal_we = 0; pal_addr = 4'h0; pal_data = 4'h0;
    #1;
    chk("rst_pix_out", int'(pix_out2), 0);
    chk("rst_pix_valid", int'(pix_valid2), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Text foreground, first pixel appears on the second strobe.
    issue(4'hE, 4'hE);
    chk("valid_after_1", int'(pix_valid2), 0);
    issue(4'hE, 4'hE);
    chk("valid_after_2", int'(pix_valid2), 1);
    issue(4'hE, 4'hE);

    blink_enabled = 1; att_byte = 8'h9E; pix_in = 0;
    issue(4'h1, 4'h1);
    pix_in = 1;
    issue(4'hE, 4'hE);

    // Divide-by-2 toggles after pulses 2 and 4; divide-by-1 after every pulse.
    blink_pulse(); issue(4'hE, 4'h1);
    blink_pulse(); issue(4'h1, 4'hE);
    blink_pulse(); issue(4'h1, 4'h1);
    blink_pulse(); issue(4'hE, 4'hE);

    blink_enabled = 0; att_byte = 8'h1E;
    issue(4'hE, 4'hE);
    pal_we = 1; pal_addr = 4'hE; pal_data = 4'h3;
    issue(4'h3, 4'h3);
    pal_we = 0;
    issue(4'h3, 4'h3);

    hsync = 1;
    issue(4'h0, 4'h0);
    hsync = 0; mode_640 = 1; pix_640 = 0;
    issue(4'h0, 4'h0);
    pix_640 = 1; att_byte = 8'h17;
    issue(4'h7, 4'h7);
    mode_640 = 0; pix_640 = 0;
    display_enable = 0; cga_color_reg = 8'h05;
    issue(4'h5, 4'h5);
    display_enable = 1;

    grph_mode = 1; cga_color_reg = 8'h13;
    issue(4'h3, 4'h3);
    c1 = 1;
    issue(4'hC, 4'hC);
    c1 = 0; c0 = 1; bw_mode = 1;
    issue(4'hB, 4'hB);
    bw_mode = 0;
    issue(4'hA, 4'hA);
    c0 = 0; tandy_16_mode = 1; pix_tandy = 4'h9;
    issue(4'h9, 4'h9);
    issue(4'h9, 4'h9);

    pix_ce = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_pix_out", int'(pix_out2), 9);
      chk("hold_pix_valid", int'(pix_valid2), 1);
    end

    grph_mode = 0; tandy_16_mode = 0; att_byte = 8'h1E; pix_in = 1;
    issue(4'h3, 4'h3);
    issue(4'h3, 4'h3);

    // Reset lands between edges and must act immediately.
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pix_out", int'(pix_out2), 0);
    chk("async_rst_pix_valid", int'(pix_valid2), 0);
    chk("async_rst_pix_valid1", int'(pix_valid1), 0);
    q2.delete();
    q1.delete();
    pix_ce = 0;
    @(negedge clk);
    reset = 1'b0;

    issue(4'hE, 4'hE);
    issue(4'hE, 4'hE);
    issue(4'hE, 4'hE);

    pix_ce = 1;
    @(negedge clk);
    pix_ce = 0;
    repeat (2) @(negedge clk);
    chk("sb2_drain", q2.size(), 0);
    chk("sb1_drain", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cga_attrib_pipe.md
CGA_ATTRIB_PIPE -- requirements
Module: cga_attrib_pipe

Interface
REQ-001 Parameter PIX_W, default 4: output colour width, legal range 4..8.
REQ-002 Parameter BLINK_DIV, default 2: number of cursor-blink rising edges per character-blink toggle, legal range 1..15.
REQ-003 clk  in  1  system clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 pix_ce  in  1  pixel clock enable; pipeline advances only when high.
REQ-006 att_byte  in  8  text attribute: [3:0] fg, [6:4] bg, [7] blink/bg-intensity.
REQ-007 cga_color_reg  in  8  [3:0] overscan colour, [4] intensity, [5] palette-blue select.
REQ-008 grph_mode, bw_mode, mode_640, tandy_16_mode, blink_enabled  in  1 each  mode controls.
REQ-009 display_enable, hsync, vsync, cursor, blink  in  1 each  timing inputs.
REQ-010 pix_in, c0, c1, pix_640  in  1 each  text dot, 4-colour bits, 640-mode dot.
REQ-011 pix_tandy  in  4  16-colour graphics index.
REQ-012 pal_we  in  1  palette write strobe, independent of pix_ce.
REQ-013 pal_addr  in  4  palette entry index.
REQ-014 pal_data  in  PIX_W  palette entry value.
REQ-015 pix_out  out  PIX_W  registered output colour.
REQ-016 pix_valid  out  1  high when pix_out holds a pixel computed since reset.

Function
REQ-017 Stage 1 (on clk when pix_ce=1) SHALL register a 4-bit colour index and a blank flag.
REQ-018 Index selection: text fg {mux_b=0,mux_a=0}; text bg {0,1}; graphics {1,0}; overscan cga_color_reg[3:0] {1,1}.
REQ-019 mux_b = grph_mode | ~display_enable.
REQ-020 mux_a = ~display_enable | (grph_mode ? (tandy_16_mode ? 0 : ~(~mode_640 & (c0|c1))) : ~alpha_dots).
REQ-021 alpha_dots = (pix_in & (~(blink_enabled & att_byte[7] & ~cursor) | ~blinkdiv)) | (cursor & blink).
REQ-022 bg = blink_enabled ? {0, att_byte[6:4]} : att_byte[7:4].
REQ-023 Graphics index = tandy_16_mode ? pix_tandy : {cga_color_reg[4], c1, c0, bw_mode ? c0 : cga_color_reg[5]}.
REQ-024 blank = hsync | vsync | (mode_640 & ~(display_enable & pix_640)).
REQ-025 Stage 2 (on pix_ce=1) SHALL load pix_out = blank ? 0 : palette[index], using stage-1 registers; latency exactly 2 pix_ce strobes.
REQ-026 pix_out and pix_valid SHALL hold when pix_ce=0.
REQ-027 Palette: 16 x PIX_W registers; pal_we=1 writes pal_data to pal_addr on clk regardless of pix_ce.
REQ-028 Palette write and stage-2 read of same entry in same cycle: stage 2 loads OLD value.
REQ-029 Blink edge detect: 2-bit shift register of blink sampled every clk (not gated by pix_ce); rising edge = pattern 01.
REQ-030 Blink divider: 4-bit counter increments per rising edge; at BLINK_DIV-1 it wraps to 0 and blinkdiv toggles.
REQ-031 BLINK_DIV=1: blinkdiv toggles on every blink rising edge.
REQ-032 pix_valid SHALL set on the second pix_ce strobe after reset and remain set until reset.

Reset
REQ-033 reset=1 SHALL immediately clear pix_out, pix_valid, stage-1 index, blinkdiv, divider counter, and edge register; set stage-1 blank.
REQ-034 Reset SHALL load palette entry i with zero-extended i.
REQ-035 Reset assertion mid-frame SHALL take effect without waiting for clk or pix_ce.

Verification
REQ-036 After reset, pix_ce every cycle, text mode, att_byte=0x1E, pix_in=1, DE=1, syncs=0 -> pix_out=0xE from 2nd strobe, pix_valid=1 at the same time.
REQ-037 Same stimulus, pix_in=0, blink_enabled=1, att_byte=0x9E -> pix_out=0x1; pix_in=1 with blinkdiv=1 -> 0x1, blinkdiv=0 -> 0xE.
REQ-038 BLINK_DIV=2, 4 blink pulses -> blinkdiv toggles after pulses 2 and 4; BLINK_DIV=1 -> toggles on every pulse.
REQ-039 Write palette[0xE]=0x3 with pal_we in the same cycle the index-0xE pixel reaches stage 2 -> that pixel shows 0xE, the next 0xE pixel shows 0x3.
REQ-040 hsync=1 or mode_640=1 with pix_640=0 -> pix_out=0; DE=0, cga_color_reg=0x05 -> pix_out=0x5; pix_ce=0 for 5 cycles -> pix_out unchanged.
REQ-041 Assert reset between clock edges mid-line -> pix_out=0 and pix_valid=0 asynchronously; palette[0xE] reads back 0xE afterwards.
